// File: rtl/data_memory_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states,
// latency bounds and the alignment rule used by the request checker.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  typedef enum logic {
    IDLE  = 1'b0,
    RWAIT = 1'b1
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // Illegal size counts as misaligned so the checker has a single reject term.
  function automatic logic misaligned(size_t sz, logic [1:0] lane);
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_align.sv
// Lane steering between the 32-bit memory word and the right-justified CPU
// data: store replication + byte enables, load lane select + extension.
module data_memory_align
  import data_memory_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  laneSel,
  input  logic        signExt,
  input  logic [31:0] writeData,
  input  logic [31:0] rdWord,
  output logic [31:0] wrWord,
  output logic [3:0]  byteEn,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  always_comb begin
    wrWord   = '0;
    byteEn   = '0;
    loadData = '0;
    shifted  = rdWord >> {laneSel, 3'b000};
    case (size)
      SZ_BYTE: begin
        // Replicating the byte lets the enable alone pick the target lane.
        wrWord   = {4{writeData[7:0]}};
        byteEn   = 4'b0001 << laneSel;
        loadData = signExt ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      SZ_HALF: begin
        wrWord   = {2{writeData[15:0]}};
        byteEn   = laneSel[1] ? 4'b1100 : 4'b0011;
        loadData = signExt ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      end
      SZ_WORD: begin
        wrWord   = writeData;
        byteEn   = 4'b1111;
        loadData = rdWord;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with byte/half/word access, a fixed-latency load
// path, and one-cycle error pulses for misaligned or out-of-range requests.
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clockPulse,
  input  logic        resetn,
  input  logic        req,
  output logic        ready,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        rvalid,
  output logic        error,
  output state_t      dbgState
);

  localparam int AW = $clog2(DEPTH);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_badLatency
    $error("data_memory_ctrl: LATENCY must be 1..4");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("data_memory_ctrl: DEPTH must be a power of two >= 4");
  end

  // Handshake: a request is taken on a rising edge where req, ready and at
  // least one of MemWrite/MemRead are high; ready is high only in IDLE.

  logic [31:0] mem [DEPTH];

  state_t         state;
  logic [2:0]     cnt;
  logic [AW-1:0]  capIdx;
  logic [1:0]     capLane;
  size_t          capSize;
  logic           capSignExt;

  size_t          sizeE;
  logic           accept;
  logic           outOfRange;
  logic           bad;
  logic [AW-1:0]  wordIdx;

  size_t          alSize;
  logic [1:0]     alLane;
  logic           alSignExt;
  logic [31:0]    wrWord;
  logic [3:0]     byteEn;
  logic [31:0]    loadData;

  assign sizeE      = size_t'(size);
  assign ready      = (state == IDLE);
  assign dbgState   = state;
  assign accept     = req && ready && (MemWrite || MemRead);
  // DEPTH is a power of two, so any set bit above the word index is out of range.
  assign outOfRange = (address >> (AW + 2)) != 32'd0;
  assign bad        = outOfRange || misaligned(sizeE, address[1:0]);
  assign wordIdx    = address[2 +: AW];

  // Store steering uses the live request; load steering uses what was captured.
  assign alSize    = (state == RWAIT) ? capSize    : sizeE;
  assign alLane    = (state == RWAIT) ? capLane    : address[1:0];
  assign alSignExt = (state == RWAIT) ? capSignExt : signExt;

  data_memory_align u_align (
    .size      (alSize),
    .laneSel   (alLane),
    .signExt   (alSignExt),
    .writeData (writeData),
    .rdWord    (mem[capIdx]),
    .wrWord    (wrWord),
    .byteEn    (byteEn),
    .loadData  (loadData)
  );

  // No reset on the array: contents survive resetn.
  always_ff @(posedge clockPulse) begin
    if (accept && !bad && MemWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrWord[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clockPulse or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      rvalid     <= 1'b0;
      error      <= 1'b0;
      readData   <= '0;
      capIdx     <= '0;
      capLane    <= '0;
      capSize    <= SZ_BYTE;
      capSignExt <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      error  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bad) begin
              error <= 1'b1;
            end else if (MemRead) begin
              state      <= RWAIT;
              cnt        <= 3'd1;
              capIdx     <= wordIdx;
              capLane    <= address[1:0];
              capSize    <= sizeE;
              capSignExt <= signExt;
            end
          end
        end
        RWAIT: begin
          // The array read happens at the final edge, after any same-request store.
          if (cnt == 3'(LATENCY)) begin
            rvalid   <= 1'b1;
            readData <= loadData;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
